// File: rtl/axis_rx_checker.sv
// axis_rx_checker
//   AXI4-Stream sink for the simple_tx generator. Frames 256-bit packets,
//   checks the 64-bit sequence number in each first beat, compares the declared
//   byte length (TUSER[15:0]) with the TSTRB byte count, and measures one-way
//   latency from the transmit timestamp carried in the first beat.
//
// Ports
//   ACLK, ARESET        clock, synchronous active-high reset
//   S_AXIS_*            stream slave (TDATA, TSTRB, TUSER, TVALID, TREADY, TLAST)
//   ts_now              shared free-running timestamp
//   ext_rst_count       one-cycle pulse clearing statistics
//   pkt_count           packets completed (saturating)
//   seq_err_count       sequence mismatches (saturating)
//   len_err_count       length mismatches (saturating)
//   last_latency        latency of the most recent packet
//   min_latency         minimum latency since clear
//   max_latency         maximum latency since clear
module axis_rx_checker #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_THROTTLE_PERIOD    = 0
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic                              S_AXIS_TLAST,
    input  logic [63:0]                       ts_now,
    input  logic                              ext_rst_count,
    output logic [31:0]                       pkt_count,
    output logic [31:0]                       seq_err_count,
    output logic [31:0]                       len_err_count,
    output logic [31:0]                       last_latency,
    output logic [31:0]                       min_latency,
    output logic [31:0]                       max_latency
);

    localparam int unsigned STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam logic [31:0] THR_LAST =
        (C_THROTTLE_PERIOD == 0) ? 32'd0 : 32'(C_THROTTLE_PERIOD - 1);

    typedef enum logic {
        FR_SOP,
        FR_IN_PKT
    } frame_state_t;

    typedef enum logic {
        SQ_UNLOCKED,
        SQ_LOCKED
    } seq_state_t;

    frame_state_t frame_q, frame_d;
    seq_state_t   seq_st_q, seq_st_d;
    logic [63:0]  exp_seq_q, exp_seq_d;
    logic [15:0]  accum_q, accum_d;
    logic [15:0]  decl_len_q, decl_len_d;
    logic [31:0]  thr_q, thr_d;
    logic         lat_valid_q, lat_valid_d;
    logic [31:0]  pkt_cnt_q, pkt_cnt_d;
    logic [31:0]  seq_err_q, seq_err_d;
    logic [31:0]  len_err_q, len_err_d;
    logic [31:0]  last_lat_q, last_lat_d;
    logic [31:0]  min_lat_q, min_lat_d;
    logic [31:0]  max_lat_q, max_lat_d;

    logic         tready;
    logic         beat;
    logic         first_beat;
    logic [5:0]   strb_cnt;
    logic [15:0]  len_sum;
    logic [15:0]  len_decl;
    logic [63:0]  rx_seq;
    logic [63:0]  lat_diff;
    logic [31:0]  lat_val;

    // Upper data lanes and TUSER bits are carried by the stream but not inspected here.
    logic unused_bits;
    assign unused_bits = ^{S_AXIS_TDATA[C_S_AXIS_DATA_WIDTH-1:128],
                           S_AXIS_TUSER[C_S_AXIS_TUSER_WIDTH-1:16]};

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // TREADY depends only on reset and the free-running throttle counter.
    always_comb begin
        tready = 1'b0;
        if (!ARESET) begin
            if (C_THROTTLE_PERIOD == 0) begin
                tready = 1'b1;
            end else begin
                tready = (thr_q != THR_LAST);
            end
        end
    end

    assign S_AXIS_TREADY = tready;
    assign beat          = S_AXIS_TVALID && tready;
    assign first_beat    = beat && (frame_q == FR_SOP);

    always_comb begin
        strb_cnt = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            strb_cnt = strb_cnt + 6'(S_AXIS_TSTRB[i]);
        end
    end

    assign rx_seq   = S_AXIS_TDATA[63:0];
    assign lat_diff = ts_now - S_AXIS_TDATA[127:64];
    assign lat_val  = (lat_diff[63:32] != '0) ? '1 : lat_diff[31:0];
    assign len_sum  = (first_beat ? 16'd0 : accum_q) + {10'd0, strb_cnt};
    // A single-beat packet has no stored declaration yet, so take TUSER directly.
    assign len_decl = first_beat ? S_AXIS_TUSER[15:0] : decl_len_q;

    always_comb begin
        frame_d     = frame_q;
        seq_st_d    = seq_st_q;
        exp_seq_d   = exp_seq_q;
        accum_d     = accum_q;
        decl_len_d  = decl_len_q;
        thr_d       = thr_q;
        lat_valid_d = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        seq_err_d   = seq_err_q;
        len_err_d   = len_err_q;
        last_lat_d  = last_lat_q;
        min_lat_d   = min_lat_q;
        max_lat_d   = max_lat_q;

        if (C_THROTTLE_PERIOD != 0) begin
            thr_d = (thr_q == THR_LAST) ? 32'd0 : thr_q + 32'd1;
        end

        if (beat) begin
            frame_d = S_AXIS_TLAST ? FR_SOP : FR_IN_PKT;
            accum_d = len_sum;

            if (first_beat) begin
                decl_len_d  = S_AXIS_TUSER[15:0];
                if ((seq_st_q == SQ_LOCKED) && (rx_seq != exp_seq_q)) begin
                    seq_err_d = sat_inc(seq_err_q);
                end
                seq_st_d    = SQ_LOCKED;
                exp_seq_d   = rx_seq + 64'd1;
                last_lat_d  = lat_val;
                lat_valid_d = 1'b1;
            end

            if (S_AXIS_TLAST) begin
                pkt_cnt_d = sat_inc(pkt_cnt_q);
                if (len_sum != len_decl) begin
                    len_err_d = sat_inc(len_err_q);
                end
            end
        end

        // Min/max trail last_latency by one cycle so they see the registered value.
        if (lat_valid_q) begin
            if (last_lat_q < min_lat_q) min_lat_d = last_lat_q;
            if (last_lat_q > max_lat_q) max_lat_d = last_lat_q;
        end

        // Clear overrides every statistic update from this cycle; framing,
        // length accumulation and throttling continue untouched.
        if (ext_rst_count) begin
            seq_st_d    = SQ_UNLOCKED;
            lat_valid_d = 1'b0;
            pkt_cnt_d   = '0;
            seq_err_d   = '0;
            len_err_d   = '0;
            last_lat_d  = '0;
            min_lat_d   = '1;
            max_lat_d   = '0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            frame_q     <= FR_SOP;
            seq_st_q    <= SQ_UNLOCKED;
            exp_seq_q   <= '0;
            accum_q     <= '0;
            decl_len_q  <= '0;
            thr_q       <= '0;
            lat_valid_q <= 1'b0;
            pkt_cnt_q   <= '0;
            seq_err_q   <= '0;
            len_err_q   <= '0;
            last_lat_q  <= '0;
            min_lat_q   <= '1;
            max_lat_q   <= '0;
        end else begin
            frame_q     <= frame_d;
            seq_st_q    <= seq_st_d;
            exp_seq_q   <= exp_seq_d;
            accum_q     <= accum_d;
            decl_len_q  <= decl_len_d;
            thr_q       <= thr_d;
            lat_valid_q <= lat_valid_d;
            pkt_cnt_q   <= pkt_cnt_d;
            seq_err_q   <= seq_err_d;
            len_err_q   <= len_err_d;
            last_lat_q  <= last_lat_d;
            min_lat_q   <= min_lat_d;
            max_lat_q   <= max_lat_d;
        end
    end

    assign pkt_count     = pkt_cnt_q;
    assign seq_err_count = seq_err_q;
    assign len_err_count = len_err_q;
    assign last_latency  = last_lat_q;
    assign min_latency   = min_lat_q;
    assign max_latency   = max_lat_q;

endmodule

// File: tb/tb_axis_rx_checker.sv
// Directed bench for axis_rx_checker: one instance without throttling for the
// framing/sequence/length/latency/clear behaviour, one with a throttle period
// of 4 for the TREADY pattern.
module tb_axis_rx_checker;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         areset;
    logic         areset1;
    logic [255:0] tdata;
    logic [31:0]  tstrb;
    logic [127:0] tuser;
    logic         tvalid;
    logic         tvalid1;
    logic         tlast;
    logic         tlast1;
    logic [63:0]  ts_now;
    logic         ext_rst;

    logic         tready,  tready1;
    logic [31:0]  pkt,     pkt1;
    logic [31:0]  seq_err, seq_err1;
    logic [31:0]  len_err, len_err1;
    logic [31:0]  last_lat, last_lat1;
    logic [31:0]  min_lat, min_lat1;
    logic [31:0]  max_lat, max_lat1;

    int n_assert = 0;
    int n_fail   = 0;

    axis_rx_checker dut (
        .ACLK          (clk),
        .ARESET        (areset),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TUSER  (tuser),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .S_AXIS_TLAST  (tlast),
        .ts_now        (ts_now),
        .ext_rst_count (ext_rst),
        .pkt_count     (pkt),
        .seq_err_count (seq_err),
        .len_err_count (len_err),
        .last_latency  (last_lat),
        .min_latency   (min_lat),
        .max_latency   (max_lat)
    );

    axis_rx_checker #(.C_THROTTLE_PERIOD(4)) dut_thr (
        .ACLK          (clk),
        .ARESET        (areset1),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TUSER  (tuser),
        .S_AXIS_TVALID (tvalid1),
        .S_AXIS_TREADY (tready1),
        .S_AXIS_TLAST  (tlast1),
        .ts_now        (ts_now),
        .ext_rst_count (ext_rst),
        .pkt_count     (pkt1),
        .seq_err_count (seq_err1),
        .len_err_count (len_err1),
        .last_latency  (last_lat1),
        .min_latency   (min_lat1),
        .max_latency   (max_lat1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat at a negedge and returns at the next negedge, after
    // the handshake edge, so registered results of that beat are visible.
    task automatic send(input logic [63:0] seq, input logic [63:0] tx_ts,
                        input logic [15:0] len, input logic [31:0] strb,
                        input logic last);
        tdata         = '0;
        tdata[63:0]   = seq;
        tdata[127:64] = tx_ts;
        tuser         = '0;
        tuser[15:0]   = len;
        tstrb         = strb;
        tlast         = last;
        tvalid        = 1'b1;
        @(negedge clk);
        tvalid        = 1'b0;
        tlast         = 1'b0;
    endtask

    int acc;

    initial begin
        areset  = 1'b1;
        areset1 = 1'b1;
        tdata   = '0;
        tstrb   = '0;
        tuser   = '0;
        tvalid  = 1'b0;
        tvalid1 = 1'b0;
        tlast   = 1'b0;
        tlast1  = 1'b0;
        ts_now  = 64'd1000;
        ext_rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_tready", tready, 0);
        chk("rst_tready_thr", tready1, 0);
        chk("rst_pkt", pkt, 0);
        chk("rst_min", min_lat, 32'hFFFFFFFF);
        chk("rst_max", max_lat, 0);
        chk("rst_last", last_lat, 0);
        repeat (2) @(negedge clk);
        areset  = 1'b0;
        areset1 = 1'b0;
        #1;
        chk("post_rst_tready", tready, 1);
        @(negedge clk);

        // Four back-to-back 2-beat packets, seq 5..8, latency 10
        for (int p = 0; p < 4; p++) begin
            send(64'(5 + p), 64'd990, 16'd64, 32'hFFFFFFFF, 1'b0);
            if (p == 0) chk("first_last_lat", last_lat, 10);
            send(64'(5 + p), 64'd990, 16'd64, 32'hFFFFFFFF, 1'b1);
        end
        chk("t1_pkt", pkt, 4);
        chk("t1_seq_err", seq_err, 0);
        chk("t1_len_err", len_err, 0);
        chk("t1_last", last_lat, 10);
        chk("t1_min", min_lat, 10);
        chk("t1_max", max_lat, 10);

        // Clear, then seq 0,1,3,4 as single-beat packets
        ext_rst = 1'b1;
        @(negedge clk);
        ext_rst = 1'b0;
        chk("clr_pkt", pkt, 0);
        chk("clr_min", min_lat, 32'hFFFFFFFF);
        chk("clr_last", last_lat, 0);
        send(64'd0, 64'd990, 16'd32, 32'hFFFFFFFF, 1'b1);
        chk("t2_seq0_err", seq_err, 0);
        send(64'd1, 64'd990, 16'd32, 32'hFFFFFFFF, 1'b1);
        chk("t2_seq1_err", seq_err, 0);
        send(64'd3, 64'd990, 16'd32, 32'hFFFFFFFF, 1'b1);
        chk("t2_seq3_err", seq_err, 1);
        send(64'd4, 64'd990, 16'd32, 32'hFFFFFFFF, 1'b1);
        chk("t2_seq4_err", seq_err, 1);
        chk("t2_pkt", pkt, 4);
        chk("t2_len_err", len_err, 0);

        // Length check on 16 strobed bytes
        send(64'd5, 64'd990, 16'd17, 32'h0000FFFF, 1'b1);
        chk("t3_len17", len_err, 1);
        send(64'd6, 64'd990, 16'd16, 32'h0000FFFF, 1'b1);
        chk("t3_len16", len_err, 1);
        chk("t3_seq_err", seq_err, 1);

        // Latency saturation: large positive diff and wrapped diff
        send(64'd7, 64'd1000 - 64'h2_0000_0000, 16'd32, 32'hFFFFFFFF, 1'b1);
        chk("t4_lat_big", last_lat, 32'hFFFFFFFF);
        send(64'd8, 64'd1001, 16'd32, 32'hFFFFFFFF, 1'b1);
        chk("t4_lat_wrap", last_lat, 32'hFFFFFFFF);
        @(negedge clk);
        chk("t4_max", max_lat, 32'hFFFFFFFF);
        chk("t4_min", min_lat, 10);

        // Clear coinciding with the second beat of a 3-beat packet
        send(64'd9, 64'd990, 16'd96, 32'hFFFFFFFF, 1'b0);
        ext_rst = 1'b1;
        send(64'd9, 64'd990, 16'd96, 32'hFFFFFFFF, 1'b0);
        ext_rst = 1'b0;
        chk("t5_clr_pkt", pkt, 0);
        chk("t5_clr_seq", seq_err, 0);
        chk("t5_clr_len", len_err, 0);
        chk("t5_clr_last", last_lat, 0);
        chk("t5_clr_min", min_lat, 32'hFFFFFFFF);
        chk("t5_clr_max", max_lat, 0);
        send(64'd9, 64'd990, 16'd96, 32'hFFFFFFFF, 1'b1);
        chk("t5_pkt1", pkt, 1);
        chk("t5_len_err", len_err, 0);
        chk("t5_min_held", min_lat, 32'hFFFFFFFF);
        send(64'd50, 64'd990, 16'd32, 32'hFFFFFFFF, 1'b1);
        chk("t5_new_seq", seq_err, 0);
        chk("t5_pkt2", pkt, 2);
        chk("t5_last", last_lat, 10);
        @(negedge clk);
        chk("t5_min", min_lat, 10);
        chk("t5_max", max_lat, 10);

        // Throttle period 4: TREADY low on cycles 3, 7, 11, 15
        areset1 = 1'b1;
        @(negedge clk);
        chk("t6_rst_tready", tready1, 0);
        areset1 = 1'b0;
        tvalid1 = 1'b1;
        tlast1  = 1'b1;
        acc     = 0;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t6_tready_c%0d", i), tready1, ((i % 4) != 3) ? 1 : 0);
            if (tready1) acc++;
            @(negedge clk);
            #1;
        end
        tvalid1 = 1'b0;
        tlast1  = 1'b0;
        chk("t6_beats_seen", acc, 12);
        chk("t6_pkt_count", pkt1, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_rx_checker.md
# axis_rx_checker

AXI4-Stream sink that sits directly downstream of the `simple_tx` traffic generator's M_AXIS port, in place of the loopback. It frames incoming 256-bit packets and checks the sequence number carried in each first beat. It also checks the declared byte length in TUSER against the bytes actually received, and measures one-way latency from the transmit timestamp embedded in the packet. Results are exposed as saturating counters and min/max/last latency registers for the AXI-Lite register block to sample.

## Interface
Parameters:
- C_S_AXIS_DATA_WIDTH, 256: stream data width; fixed at 256 for this block.
- C_S_AXIS_TUSER_WIDTH, 128: sideband width; only bits [15:0] are used.
- C_THROTTLE_PERIOD, 0: TREADY backpressure period; 0 = never throttle.

Ports:
- ACLK  in  1  single clock for all logic
- ARESET  in  1  synchronous, active-high reset
- S_AXIS_TDATA  in  256  stream data
- S_AXIS_TSTRB  in  32  byte qualifiers, contiguous from bit 0
- S_AXIS_TUSER  in  128  [15:0] = packet byte length, valid on first beat
- S_AXIS_TVALID  in  1  beat valid
- S_AXIS_TREADY  out  1  beat accept
- S_AXIS_TLAST  in  1  last beat of packet
- ts_now  in  64  shared free-running timestamp
- ext_rst_count  in  1  one-cycle pulse that clears statistics
- pkt_count  out  32  packets completed
- seq_err_count  out  32  sequence mismatches
- len_err_count  out  32  length mismatches
- last_latency  out  32  latency of most recent packet
- min_latency  out  32  minimum latency since clear
- max_latency  out  32  maximum latency since clear

## Operation
- A beat transfers when S_AXIS_TVALID and S_AXIS_TREADY are both 1.
- Framing FSM states:
  - SOP → IN_PKT on a beat with TLAST=0.
  - SOP → SOP on a beat with TLAST=1 (single-beat packet).
  - IN_PKT → SOP on a beat with TLAST=1.
  - No transition without a beat.
- First-beat fields: seq = TDATA[63:0], tx_ts = TDATA[127:64], decl_len = TUSER[15:0].
- Sequence FSM states are UNLOCKED and LOCKED.
  - UNLOCKED, on first beat: load exp_seq = seq+1; go to LOCKED; no error.
  - LOCKED, on first beat: if seq ≠ exp_seq, increment seq_err_count.
  - In both cases, exp_seq = seq+1 (resync). Arithmetic is mod 2^64.
- Byte length:
  - Accumulator = popcount(TSTRB) summed per beat, 16-bit.
  - The accumulator restarts with the first beat's popcount.
  - On the TLAST beat, if accum+popcount ≠ decl_len, increment len_err_count.
- Latency:
  - diff = ts_now − tx_ts, 64-bit mod 2^64, sampled on the first beat.
  - latency = diff if diff < 2^32, else 32'hFFFFFFFF.
- On the cycle after latency is registered:
  - min_latency = min(min, last); max_latency = max(max, last).
- pkt_count increments on every TLAST beat.
- All counters saturate at 32'hFFFFFFFF.
- TREADY throttle:
  - C_THROTTLE_PERIOD = P > 0: counter runs 0..P−1 and free-runs regardless of TVALID; TREADY = 0 when the counter equals P−1, 1 otherwise.
  - P = 0: TREADY is constantly 1 outside reset.
  - P = 1: illegal.
- ext_rst_count:
  - Clears all counters and last_latency to 0, max_latency to 0, min_latency to 32'hFFFFFFFF.
  - Sets the sequence FSM to UNLOCKED.
  - Does not affect the framing FSM, the length accumulator or the throttle counter.
  - A packet in flight at the clear completes normally and counts after the clear.
  - Any update that would occur in the same cycle as a clear is discarded; the clear wins.
- ARESET:
  - Framing FSM → SOP; sequence FSM → UNLOCKED; accumulator and throttle counter → 0.
  - Outputs take the clear values above; TREADY = 0.
  - Reset mid-packet discards the partial packet; the next accepted beat is treated as a first beat.

## Timing
- TREADY is 0 while ARESET is high and 1 in the first cycle after ARESET deasserts (throttle counter starts at 0).
- seq_err_count: updates in the cycle after the first-beat handshake.
- last_latency: updates in the cycle after the first-beat handshake.
- min_latency / max_latency: update 2 cycles after the first-beat handshake.
- pkt_count / len_err_count: update in the cycle after the TLAST handshake.
- Single-beat packet: the sequence, length and count updates all land 1 cycle after the beat; min/max land after 2.
- Back-to-back packets (TLAST followed by the next first beat in the following cycle): no bubble and no lost update.
- Throughput: 1 beat/cycle when TREADY=1. TREADY has no combinational dependence on TVALID.

## Test plan
- Four 2-beat packets, seq 5, 6, 7, 8, TSTRB all-ones, TUSER=64, tx_ts = ts_now−10 → pkt_count=4, seq_err_count=0, len_err_count=0, last/min/max=10.
- Seq 0, 1, 3, 4 → seq_err_count=1 one cycle after the seq-3 beat; seq 4 is accepted with no further error.
- 1-beat packet with TSTRB=0x0000FFFF and TUSER=17 → len_err_count=1; the same packet with TUSER=16 → no error.
- tx_ts = ts_now − 2^33 → last_latency=FFFFFFFF. tx_ts = ts_now+1 (wraps) → last_latency=FFFFFFFF.
- ext_rst_count pulsed while the second beat of a 3-beat packet is in flight → that packet completes with pkt_count=1, min=FFFFFFFF until the next packet, and a new first seq is accepted without error.
- C_THROTTLE_PERIOD=4 with TVALID held high for 16 cycles → TREADY low on cycles 3, 7, 11, 15; exactly 12 beats accepted.
